// File: rtl/mdb_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
package mdb_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, tick-sampled stability filter and
// an auto-repeat FSM that emits periodic pulses while the button stays held.
module debounce_channel
  import mdb_pkg::*;
#(
  parameter int STABLE_TICKS = 3,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int RW = $clog2(max(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST  = RW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
  localparam bit            RPT_EN     = (REPEAT_DELAY > 0);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_repeat;
  rpt_state_t    r_state;
  logic [RW-1:0] r_rpt;

  logic w_s;
  logic w_decide;
  logic w_press_evt;
  logic w_rel_evt;

  assign w_s         = r_sync[1];
  assign w_decide    = tick && (w_s != r_level) && (r_cnt == CNT_LAST);
  assign w_press_evt = w_decide && w_s;
  assign w_rel_evt   = w_decide && !w_s;

  assign level         = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], raw};
    end
  end

  // Any sample agreeing with the current level restarts the run, so only
  // STABLE_TICKS consecutive disagreeing samples can flip the level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_press_evt;
      r_release <= w_rel_evt;
      if (tick) begin
        if (w_s == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_level <= w_s;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Release wins over a repeat that would fall on the same tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= RPT_IDLE;
      r_rpt    <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (w_rel_evt) begin
        r_state <= RPT_IDLE;
        r_rpt   <= '0;
      end else begin
        case (r_state)
          RPT_IDLE: begin
            if (RPT_EN && w_press_evt) begin
              r_state <= RPT_DELAY;
              r_rpt   <= '0;
            end
          end
          RPT_DELAY: begin
            if (tick) begin
              if (r_rpt == DELAY_LAST) begin
                r_repeat <= 1'b1;
                r_rpt    <= '0;
                r_state  <= RPT_REPEAT;
              end else begin
                r_rpt <= r_rpt + 1'b1;
              end
            end
          end
          RPT_REPEAT: begin
            if (tick) begin
              if (r_rpt == RATE_LAST) begin
                r_repeat <= 1'b1;
                r_rpt    <= '0;
              end else begin
                r_rpt <= r_rpt + 1'b1;
              end
            end
          end
          default: begin
            r_state <= RPT_IDLE;
            r_rpt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: one shared sample-tick generator driving
// N_CH independent debounce_channel instances.
module multi_debouncer
  import mdb_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 25000,
  parameter int STABLE_TICKS = 3,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            tick
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);
  assign tick   = w_tick;

  // Explicit wrap keeps the period exact for non-power-of-two dividers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (w_tick),
      .raw          (btn_in[g]),
      .level        (btn_level[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .repeat_pulse (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios with hand-timed expectations and a
// randomized phase, all compared every cycle against a tick-window reference model.
module tb_multi_debouncer;

  localparam int N_CH         = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int REPEAT_DELAY = 5;
  localparam int REPEAT_RATE  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;
  logic            tick;

  int nCompared   = 0;
  int nMismatched = 0;

  multi_debouncer #(
    .N_CH        (N_CH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] btn, input int cycles);
    btn_in = btn;
    repeat (cycles) @(negedge clk);
  endtask

  // Returns at a negedge where tick is high, so the next drive lines up with a known phase.
  task automatic alignToTick();
    int guard;
    guard = 0;
    while (tick !== 1'b1 && guard < 2 * TICK_DIV) begin
      @(negedge clk);
      guard++;
    end
    if (tick !== 1'b1) checkOutput("align_tick_timeout", 32'(tick), 32'd1);
  endtask

  // Reference model: level flips when the last STABLE_TICKS tick samples of the
  // synchronised input all disagree with it; repeats are tick offsets from the press.
  int              mCyc;
  int              mTickIdx;
  logic [N_CH-1:0] mHist0;
  logic [N_CH-1:0] mHist1;
  logic [STABLE_TICKS-1:0] mWin [N_CH];
  int              mPressTick [N_CH];
  logic [N_CH-1:0] expLevel;
  logic [N_CH-1:0] expPress;
  logic [N_CH-1:0] expRelease;
  logic [N_CH-1:0] expRepeat;
  logic            expTick;
  bit              modelValid = 1'b0;

  always @(posedge clk) begin : refModel
    logic [N_CH-1:0] sNow;
    bit              tk;
    int              e;
    if (!rst_n) begin
      mCyc       = 0;
      mTickIdx   = 0;
      mHist0     = '0;
      mHist1     = '0;
      expLevel   = '0;
      expPress   = '0;
      expRelease = '0;
      expRepeat  = '0;
      expTick    = 1'b0;
      for (int ch = 0; ch < N_CH; ch++) begin
        mWin[ch]       = '0;
        mPressTick[ch] = 0;
      end
      modelValid = 1'b1;
    end else begin
      tk         = ((mCyc % TICK_DIV) == TICK_DIV - 1);
      sNow       = mHist1;
      expPress   = '0;
      expRelease = '0;
      expRepeat  = '0;
      if (tk) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          mWin[ch] = (mWin[ch] << 1) | STABLE_TICKS'(sNow[ch]);
          if (expLevel[ch] ? (mWin[ch] == '0) : (&mWin[ch])) begin
            expLevel[ch] = ~expLevel[ch];
            if (expLevel[ch]) begin
              expPress[ch]   = 1'b1;
              mPressTick[ch] = mTickIdx;
            end else begin
              expRelease[ch] = 1'b1;
            end
          end else if (expLevel[ch] && REPEAT_DELAY > 0) begin
            e = mTickIdx - mPressTick[ch];
            if (e == REPEAT_DELAY || (e > REPEAT_DELAY && ((e - REPEAT_DELAY) % REPEAT_RATE) == 0))
              expRepeat[ch] = 1'b1;
          end
        end
        mTickIdx++;
      end
      mHist1  = mHist0;
      mHist0  = btn_in;
      mCyc++;
      expTick = ((mCyc % TICK_DIV) == TICK_DIV - 1);
    end
  end

  always @(negedge clk) begin : compareProc
    if (modelValid) begin
      checkOutput("model_tick",    32'(tick),          32'(expTick));
      checkOutput("model_level",   32'(btn_level),     32'(expLevel));
      checkOutput("model_press",   32'(press_pulse),   32'(expPress));
      checkOutput("model_release", 32'(release_pulse), 32'(expRelease));
      checkOutput("model_repeat",  32'(repeat_pulse),  32'(expRepeat));
    end
  end

  // Pulse bookkeeping used by the directed scenarios.
  int negCnt = 0;
  int pressCnt    [N_CH] = '{default: 0};
  int relCnt      [N_CH] = '{default: 0};
  int lastPressAt [N_CH] = '{default: 0};
  int rptAt2 [$];

  always @(negedge clk) begin : recorder
    negCnt++;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (press_pulse[ch] === 1'b1) begin
        pressCnt[ch]++;
        lastPressAt[ch] = negCnt;
      end
      if (release_pulse[ch] === 1'b1) relCnt[ch]++;
    end
    if (repeat_pulse[2] === 1'b1) rptAt2.push_back(negCnt);
  end

  logic [N_CH-1:0] rndCur;
  int              rndDur [N_CH];
  int              snapP, snapR, snapQ, guard;

  initial begin
    btn_in = '1;
    rst_n  = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("reset_level",   32'(btn_level),     32'h0);
    checkOutput("reset_press",   32'(press_pulse),   32'h0);
    checkOutput("reset_release", 32'(release_pulse), 32'h0);
    checkOutput("reset_repeat",  32'(repeat_pulse),  32'h0);
    checkOutput("reset_tick",    32'(tick),          32'h0);

    btn_in = '0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("first_tick", 32'(tick), 32'(i == 3));
      if (i == 0) rst_n = 1'b1;
      @(negedge clk);
    end

    $display("[TB] clean press on ch0");
    alignToTick();
    snapP = pressCnt[0];
    applyStimulus(4'b0001, 12);
    checkOutput("press0_early", 32'(press_pulse), 32'h0);
    applyStimulus(4'b0001, 1);
    checkOutput("press0_pulse", 32'(press_pulse), 32'b0001);
    checkOutput("press0_level", 32'(btn_level), 32'b0001);
    applyStimulus(4'b0001, 27);
    checkOutput("press0_count", 32'(pressCnt[0] - snapP), 32'd1);
    checkOutput("press0_hold_level", 32'(btn_level), 32'b0001);
    snapR = relCnt[0];
    applyStimulus(4'b0000, 30);
    checkOutput("release0_count", 32'(relCnt[0] - snapR), 32'd1);

    $display("[TB] glitch and bounce on ch1");
    alignToTick();
    snapP = pressCnt[1];
    snapR = relCnt[1];
    applyStimulus(4'b0010, 8);
    applyStimulus(4'b0000, 24);
    checkOutput("glitch_level", 32'(btn_level), 32'h0);
    checkOutput("glitch_press", 32'(pressCnt[1] - snapP), 32'd0);
    checkOutput("glitch_release", 32'(relCnt[1] - snapR), 32'd0);
    alignToTick();
    snapP = pressCnt[1];
    applyStimulus(4'b0010, 4);
    applyStimulus(4'b0000, 4);
    applyStimulus(4'b0010, 12);
    checkOutput("bounce_early", 32'(press_pulse), 32'h0);
    applyStimulus(4'b0010, 1);
    checkOutput("bounce_pulse", 32'(press_pulse), 32'b0010);
    applyStimulus(4'b0010, 10);
    checkOutput("bounce_count", 32'(pressCnt[1] - snapP), 32'd1);
    applyStimulus(4'b0000, 30);

    $display("[TB] auto-repeat on ch2");
    alignToTick();
    snapQ = rptAt2.size();
    snapR = relCnt[2];
    applyStimulus(4'b0100, 13);
    checkOutput("rpt_press_pulse", 32'(press_pulse), 32'b0100);
    applyStimulus(4'b0100, 53);
    checkOutput("rpt_count_13_ticks", 32'(rptAt2.size() - snapQ), 32'd5);
    if (rptAt2.size() >= snapQ + 2) begin
      checkOutput("rpt_first_offset", 32'(rptAt2[snapQ] - lastPressAt[2]), 32'(REPEAT_DELAY * TICK_DIV));
      checkOutput("rpt_gap", 32'(rptAt2[snapQ+1] - rptAt2[snapQ]), 32'(REPEAT_RATE * TICK_DIV));
    end
    btn_in = 4'b0000;
    guard  = 0;
    while (release_pulse[2] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) checkOutput("rpt_release_timeout", 32'(release_pulse), 32'b0100);
    snapQ = rptAt2.size();
    applyStimulus(4'b0000, 40);
    checkOutput("rpt_after_release", 32'(rptAt2.size() - snapQ), 32'd0);
    checkOutput("rpt_release_count", 32'(relCnt[2] - snapR), 32'd1);

    $display("[TB] simultaneous channels");
    alignToTick();
    applyStimulus(4'b1001, 12);
    checkOutput("simul_press_early", 32'(press_pulse), 32'h0);
    applyStimulus(4'b1001, 1);
    checkOutput("simul_press", 32'(press_pulse), 32'b1001);
    applyStimulus(4'b1001, 20);
    alignToTick();
    applyStimulus(4'b0001, 12);
    checkOutput("simul_release_early", 32'(release_pulse), 32'h0);
    applyStimulus(4'b0001, 1);
    checkOutput("simul_release", 32'(release_pulse), 32'b1000);
    applyStimulus(4'b0000, 40);

    $display("[TB] reset during repeat");
    alignToTick();
    applyStimulus(4'b0100, 38);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_level",   32'(btn_level),     32'h0);
    checkOutput("midrst_press",   32'(press_pulse),   32'h0);
    checkOutput("midrst_release", 32'(release_pulse), 32'h0);
    checkOutput("midrst_repeat",  32'(repeat_pulse),  32'h0);
    checkOutput("midrst_tick",    32'(tick),          32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0100, 11);
    checkOutput("midrst_press_early", 32'(press_pulse), 32'h0);
    applyStimulus(4'b0100, 1);
    checkOutput("midrst_repress", 32'(press_pulse), 32'b0100);
    applyStimulus(4'b0000, 30);

    $display("[TB] randomized phase");
    rndCur = '0;
    for (int ch = 0; ch < N_CH; ch++) rndDur[ch] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (rndDur[ch] == 0) begin
          rndCur[ch] = ~rndCur[ch];
          rndDur[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 120))
                                                   : int'($urandom_range(1, 12));
        end else begin
          rndDur[ch]--;
        end
      end
      if (cyc == 1500) rst_n = 1'b0;
      if (cyc == 1503) rst_n = 1'b1;
      applyStimulus(rndCur, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
